// File: rtl/btn_debounce2.sv
// Two-channel button conditioner: a 2-flop synchronizer per raw input feeding an
// independent debounce FSM with a stability counter. Each channel produces a
// registered debounced level and a one-cycle rising-edge tick.

module btn_debounce2_chan #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic tick
);

  // LOW/HIGH are settled levels; WAIT1/WAIT0 qualify a candidate new level.
  typedef enum logic [1:0] {
    ST_LOW   = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_HIGH  = 2'b10,
    ST_WAIT0 = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             tick_next;

  // Two-flop synchronizer; only s2 is seen by the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_LOW;
      cnt   <= '0;
      level <= 1'b0;
      tick  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      tick  <= tick_next;
    end
  end

  // Next-state and counter update; any bounce while waiting drops back.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_LOW: begin
        if (s2) begin
          state_next = ST_WAIT1;
          cnt_next   = '0;
        end
      end
      ST_WAIT1: begin
        if (!s2) begin
          state_next = ST_LOW;
        end else if (cnt == CNT_MAX) begin
          state_next = ST_HIGH;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s2) begin
          state_next = ST_WAIT0;
          cnt_next   = '0;
        end
      end
      ST_WAIT0: begin
        if (s2) begin
          state_next = ST_HIGH;
        end else if (cnt == CNT_MAX) begin
          state_next = ST_LOW;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_LOW;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the next state so the registered level changes on the
  // same edge as the state; the tick marks only the accepted press.
  always_comb begin
    level_next = (state_next == ST_HIGH) || (state_next == ST_WAIT0);
    tick_next  = (state == ST_WAIT1) && (state_next == ST_HIGH);
  end

endmodule

module btn_debounce2 #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_tick,
  output logic b_tick
);

  btn_debounce2_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_a (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_a_raw),
    .level (a),
    .tick  (a_tick)
  );

  btn_debounce2_chan #(
    .DB_CYCLES (DB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_chan_b (
    .clk   (clk),
    .reset (reset),
    .raw   (btn_b_raw),
    .level (b),
    .tick  (b_tick)
  );

endmodule

// File: doc/btn_debounce2.md
# btn_debounce2

Two-channel input conditioner for the lab FSM designs: it takes two raw, asynchronous push-button or switch signals and produces clean, clock-synchronous `a` and `b` levels, plus single-cycle rising-edge ticks. It sits directly upstream of the two-input Moore/Mealy state machine and drives that block's `a` and `b` inputs. Each channel has a 2-flop synchronizer followed by an independent 4-state debounce FSM with a stability counter.

## Interface
- `DB_CYCLES`, default 1_000_000: number of consecutive cycles a synchronized input must hold a new value before it is accepted (10 ms at 100 MHz). Must be ≥ 2.
- `CNT_W`, default 20: width of each stability counter. Must satisfy 2^CNT_W ≥ DB_CYCLES.
- `clk` input 1: system clock, rising-edge active.
- `reset` input 1: asynchronous, active-high.
- `btn_a_raw` input 1: raw asynchronous input, channel A.
- `btn_b_raw` input 1: raw asynchronous input, channel B.
- `a` output 1: debounced level, channel A. Connects to the FSM input `a`.
- `b` output 1: debounced level, channel B. Connects to the FSM input `b`.
- `a_tick` output 1: one-cycle pulse when `a` goes 0→1.
- `b_tick` output 1: one-cycle pulse when `b` goes 0→1.

## Operation
- **Synchronizer.** Each raw input passes through two flops (`s1`, then `s2`). Only `s2` feeds the FSM.
- **Per-channel FSM.** States are LOW, WAIT1, HIGH and WAIT0, each with a counter `cnt`. Transitions:
  - LOW: if `s2`=1, go to WAIT1 and clear `cnt`. Otherwise stay.
  - WAIT1: if `s2`=0, go to LOW. Otherwise, if `cnt`=DB_CYCLES-1, go to HIGH. Otherwise increment `cnt`.
  - HIGH: if `s2`=0, go to WAIT0 and clear `cnt`. Otherwise stay.
  - WAIT0: if `s2`=1, go to HIGH. Otherwise, if `cnt`=DB_CYCLES-1, go to LOW. Otherwise increment `cnt`.
  - Unused or illegal encodings go to LOW.
- **Level output.** The level is 1 in HIGH and WAIT0, and 0 in LOW and WAIT1. It is registered and decoded from the state register, so there is no combinational path from the inputs.
- **Tick output.** The tick is a registered signal, set in the cycle the state moves WAIT1→HIGH and held for that one cycle. It is never set on the falling transition.
- **Channel independence.** The two channels are fully independent. Simultaneous activity on both channels gives `a` and `b` rising in the same cycle, with both ticks in that same cycle.
- **Reset.** While `reset` is asserted, all of the following are 0 asynchronously:
  - `s1` and `s2`
  - the states (held in LOW)
  - both counters
  - `a`, `b`, `a_tick`, `b_tick`
- **Reset mid-operation.** Any partial count is discarded. A button still held after reset is released is treated as a fresh press: it goes through WAIT1 and produces exactly one tick.

## Timing
- Edge E0 is the first rising edge that samples the raw input at its new value.
  - `s2` reflects the new value after E1.
  - The FSM enters WAIT1 (or WAIT0) after E2, with `cnt`=0.
  - `cnt` reaches DB_CYCLES-1 after E(DB_CYCLES+1).
  - The state changes after E(DB_CYCLES+2).
- **Press latency.** From E0 to the `a`/`b` change is DB_CYCLES+2 edges. `a_tick` is high during exactly the cycle following E(DB_CYCLES+2), which is the first cycle `a`=1.
- **Release latency.** The release latency is identical, DB_CYCLES+2 edges, with no tick.
- **Glitch rejection.** A synchronized pulse shorter than DB_CYCLES cycles, in either polarity, produces no output change and no tick.
- **Bounce.** Any bounce during WAIT1 or WAIT0 restarts qualification from the beginning.
- **Tick spacing.** At most one tick per accepted press. The minimum spacing between ticks on one channel is 2·DB_CYCLES+2 cycles.
- **Downstream use.** The downstream FSM can sample `a` and `b` directly. The outputs are stable for at least DB_CYCLES cycles between changes.

## Test plan
All tests use `DB_CYCLES`=4 and `CNT_W`=3.
- **Clean press A.** Reset, then `btn_a_raw`=1 from E0 and held → `a`=1 after E6. `a_tick`=1 only in the cycle after E6. `b` and `b_tick` stay 0.
- **Glitch.** `btn_a_raw`=1 for 3 cycles, then 0 → `a` and `a_tick` stay 0 throughout. The FSM returns to LOW.
- **Bounce then stable.** `btn_b_raw` = 1,0,1,0,1 (one cycle each), then held 1 → exactly one `b_tick`. `b` rises 6 edges after the final 0→1 sample.
- **Release.** With `a`=1, `btn_a_raw`=0 from E0 → `a`=0 after E6 with no tick. A 2-cycle low glitch instead leaves `a`=1.
- **Simultaneous.** Both raw inputs rise on the same edge → `a`/`b` rise together and `a_tick`/`b_tick` pulse in the same cycle. Combined with the downstream FSM in S0, its Mealy output `y0` is 1 in that cycle.
- **Reset mid-count.** Assert `reset` while channel A is in WAIT1 with `cnt`=2 → all outputs 0 immediately. `btn_a_raw` is held 1 through reset release; `a` rises 6 edges after the first post-release edge, with a single tick.
